// File: rtl/key_match_engine_if.sv
// Key request / lookup result bundle between a key source and the match engine.
// Latency: none; this is wiring only.
// Backpressure: key_alful throttles the key source; gme_alful throttles the engine's lookups.
interface key_match_engine_if;
  logic         key_wr;
  logic         key_valid;
  logic [511:0] key;
  logic         key_alful;
  logic         id_wr;
  logic [15:0]  id;
  logic         gme_alful;

  // Key source / result consumer side
  modport master (
    output key_wr, key_valid, key, gme_alful,
    input  key_alful, id_wr, id
  );

  // Match engine side
  modport slave (
    input  key_wr, key_valid, key, gme_alful,
    output key_alful, id_wr, id
  );
endinterface

// File: rtl/key_match_engine.sv
// 512-bit exact-match lookup of queued keys against a 16-entry table, returning an id per key.
// Latency: key_wr at cycle T into an idle engine gives id_wr at T+3; one result per cycle sustained.
// Backpressure: keys dropped (and counted) when the FIFO is full; gme_alful stalls pops, in-flight lookups drain.
module key_match_engine #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          ALFUL_TH   = 6,
  parameter logic [15:0] MISS_ID    = 16'hFFFF
) (
  input  logic                clk,
  input  logic                reset,
  key_match_engine_if.slave   km,
  input  logic                cfg_wr,
  input  logic [3:0]          cfg_idx,
  input  logic                cfg_en,
  input  logic [511:0]        cfg_key,
  input  logic [15:0]         cfg_id,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt,
  output logic [15:0]         drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Key FIFO: each entry is {key_valid, key}
  logic [512:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;
  logic          key_alful_q;

  // Lookup stage S1
  logic          s1_vld;
  logic          s1_kv;
  logic [511:0]  s1_key;

  // Match table
  logic [15:0]   tbl_en;
  logic [511:0]  tbl_key [16];
  logic [15:0]   tbl_id  [16];

  // Match result
  logic          hit;
  logic [15:0]   hit_id;
  logic          id_wr_q;
  logic [15:0]   id_q;

  assign km.key_alful = key_alful_q;
  assign km.id_wr     = id_wr_q;
  assign km.id        = id_q;

  // Full is judged on the pre-pop occupancy, so a same-cycle pop never frees room for a push.
  always_comb begin
    full      = (count == CW'(FIFO_DEPTH));
    empty     = (count == '0);
    push      = km.key_wr && !full;
    drop      = km.key_wr && full;
    pop       = !empty && !km.gme_alful;
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // FIFO storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {km.key_valid, km.key};
  end

  // FIFO pointers, occupancy, registered almost-full and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_alful_q <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= count_nxt;
      key_alful_q <= (count_nxt >= CW'(ALFUL_TH));
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Popped entry loads S1; only the valid flag is reset.
  always_ff @(posedge clk) begin
    if (reset) s1_vld <= 1'b0;
    else       s1_vld <= pop;
    if (pop) {s1_kv, s1_key} <= fifo_mem[rd_ptr];
  end

  // Table update lands on the edge, so a lookup in S1 this cycle still sees the old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tbl_en <= '0;
    end else if (cfg_wr) begin
      tbl_en[cfg_idx]  <= cfg_en;
      tbl_key[cfg_idx] <= cfg_key;
      tbl_id[cfg_idx]  <= cfg_id;
    end
  end

  // Parallel compare; scanning high to low lets the lowest matching index win.
  always_comb begin
    hit    = 1'b0;
    hit_id = MISS_ID;
    for (int i = 15; i >= 0; i--) begin
      if (s1_kv && tbl_en[i] && (tbl_key[i] == s1_key)) begin
        hit    = 1'b1;
        hit_id = tbl_id[i];
      end
    end
  end

  // Result register and hit/miss counters; id holds its last value between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_wr_q  <= 1'b0;
      id_q     <= 16'h0000;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      id_wr_q <= s1_vld;
      if (s1_vld) begin
        id_q <= hit_id;
        if (hit) hit_cnt  <= hit_cnt + 32'd1;
        else     miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_match_engine.sv
// Directed bench for key_match_engine with an in-order id scoreboard and hit/miss model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: gme_alful and key_alful/drop behaviour driven explicitly.
module tb_key_match_engine;

  localparam logic [15:0] MISS = 16'hFFFF;
  localparam logic [511:0] K1 = {16{32'h1111_1111}};
  localparam logic [511:0] K2 = {16{32'h2222_2222}};
  localparam logic [511:0] K3 = {16{32'h3333_3333}};
  localparam logic [511:0] K9 = {16{32'h9999_9999}};

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_wr;
  logic [3:0]   cfg_idx;
  logic         cfg_en;
  logic [511:0] cfg_key;
  logic [15:0]  cfg_id;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
  logic [15:0]  drop_cnt;

  key_match_engine_if kif();

  key_match_engine dut (
    .clk      (clk),
    .reset    (reset),
    .km       (kif),
    .cfg_wr   (cfg_wr),
    .cfg_idx  (cfg_idx),
    .cfg_en   (cfg_en),
    .cfg_key  (cfg_key),
    .cfg_id   (cfg_id),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] sb[$];
  int          m_hit = 0;
  int          m_miss = 0;
  logic [15:0] last_id = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: consume inputs on the rising edge, check outputs on the falling edge.
  task automatic step();
    logic        rst_at_edge;
    logic [15:0] exp_id;
    @(posedge clk);
    rst_at_edge = reset;
    @(negedge clk);
    if (rst_at_edge) begin
      m_hit   = 0;
      m_miss  = 0;
      last_id = 16'h0000;
      chk("reset_id_wr", {31'd0, kif.id_wr}, 32'd0);
      chk("reset_id", {16'd0, kif.id}, 32'd0);
    end else if (kif.id_wr) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_id_wr observed=%0h expected=no_result", kif.id);
      end
      if (sb.size() != 0) begin
        exp_id = sb.pop_front();
        if (exp_id == MISS) m_miss++;
        else                m_hit++;
        chk("result_id", {16'd0, kif.id}, {16'd0, exp_id});
        chk("hit_cnt", hit_cnt, 32'(m_hit));
        chk("miss_cnt", miss_cnt, 32'(m_miss));
      end
      last_id = kif.id;
    end else begin
      chk("id_hold", {16'd0, kif.id}, {16'd0, last_id});
    end
  endtask

  task automatic cfg(input logic [3:0] idx, input logic en, input logic [511:0] k, input logic [15:0] id);
    cfg_wr  = 1'b1;
    cfg_idx = idx;
    cfg_en  = en;
    cfg_key = k;
    cfg_id  = id;
    step();
    cfg_wr  = 1'b0;
  endtask

  task automatic send(input logic [511:0] k, input logic v, input logic expect_out, input logic [15:0] exp_id);
    kif.key_wr    = 1'b1;
    kif.key_valid = v;
    kif.key       = k;
    if (expect_out) sb.push_back(exp_id);
    step();
    kif.key_wr    = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [511:0] ka(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + 32'(i);
    return {16{w}};
  endfunction

  initial begin
    reset         = 1'b1;
    cfg_wr        = 1'b0;
    cfg_idx       = '0;
    cfg_en        = 1'b0;
    cfg_key       = '0;
    cfg_id        = '0;
    kif.key_wr    = 1'b0;
    kif.key_valid = 1'b0;
    kif.key       = '0;
    kif.gme_alful = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_key_alful", {31'd0, kif.key_alful}, 32'd0);
    chk("rst_id_wr", {31'd0, kif.id_wr}, 32'd0);
    chk("rst_id", {16'd0, kif.id}, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Single hit and T+3 latency
    cfg(4'd3, 1'b1, K1, 16'h0042);
    send(K1, 1'b1, 1'b1, 16'h0042);
    chk("lat_t1", {31'd0, kif.id_wr}, 32'd0);
    step();
    chk("lat_t2", {31'd0, kif.id_wr}, 32'd0);
    step();
    chk("lat_t3", {31'd0, kif.id_wr}, 32'd1);
    chk("lat_hit_cnt", hit_cnt, 32'd1);
    step();

    // Lowest index wins, disable, invalid key, unknown key
    cfg(4'd2, 1'b1, K2, 16'h0002);
    cfg(4'd5, 1'b1, K2, 16'h0005);
    send(K2, 1'b1, 1'b1, 16'h0002);
    drain("drain_prio");
    cfg(4'd2, 1'b0, K2, 16'h0002);
    send(K2, 1'b1, 1'b1, 16'h0005);
    drain("drain_disabled");
    send(K2, 1'b0, 1'b1, MISS);
    drain("drain_invalid");
    send(K9, 1'b1, 1'b1, MISS);
    drain("drain_unknown");
    chk("miss_cnt_after_misses", miss_cnt, 32'd2);

    // Downstream stall: fill, almost-full, drops, then back-to-back release
    for (int j = 0; j < 8; j++) cfg(4'(8 + j), 1'b1, ka(j), 16'h0100 + 16'(j));
    kif.gme_alful = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(ka(i), 1'b1, (i < 8), 16'h0100 + 16'(i));
      chk("fill_key_alful", {31'd0, kif.key_alful}, {31'd0, (i + 1 >= 6)});
      chk("fill_no_id_wr", {31'd0, kif.id_wr}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_id_wr", {31'd0, kif.id_wr}, 32'd0);
    end
    chk("drop_cnt_2", {16'd0, drop_cnt}, 32'd2);
    // Push on full with a same-cycle pop is still a drop
    kif.gme_alful = 1'b0;
    send(ka(9), 1'b1, 1'b0, 16'h0000);
    chk("drop_cnt_full_pop", {16'd0, drop_cnt}, 32'd3);
    begin
      int n = 0;
      while (!kif.id_wr && n < 5) begin
        step();
        n++;
      end
    end
    chk("release_first", {31'd0, kif.id_wr}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("release_b2b", {31'd0, kif.id_wr}, 32'd1);
    end
    step();
    chk("release_end", {31'd0, kif.id_wr}, 32'd0);
    chk("release_queue", 32'(sb.size()), 32'd0);
    chk("release_key_alful", {31'd0, kif.key_alful}, 32'd0);

    // Table write while the key sits in S1 uses the old entry
    cfg(4'd0, 1'b1, K3, 16'h0010);
    send(K3, 1'b1, 1'b1, 16'h0010);
    step();
    cfg(4'd0, 1'b1, K3, 16'h0011);
    send(K3, 1'b1, 1'b1, 16'h0011);
    drain("drain_cfg_race");

    // Reset with keys in FIFO, S1 and result; key_wr during reset ignored
    kif.gme_alful = 1'b1;
    send(K1, 1'b1, 1'b1, 16'h0042);
    send(K1, 1'b1, 1'b0, 16'h0000);
    send(K1, 1'b1, 1'b0, 16'h0000);
    send(K1, 1'b1, 1'b0, 16'h0000);
    step();
    chk("pre_rst_stall", {31'd0, kif.id_wr}, 32'd0);
    kif.gme_alful = 1'b0;
    step();
    step();
    chk("pre_rst_emitted", 32'(sb.size()), 32'd0);
    reset         = 1'b1;
    kif.key_wr    = 1'b1;
    kif.key_valid = 1'b1;
    kif.key       = K1;
    step();
    reset      = 1'b0;
    kif.key_wr = 1'b0;
    chk("post_rst_hit_cnt", hit_cnt, 32'd0);
    chk("post_rst_miss_cnt", miss_cnt, 32'd0);
    chk("post_rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    chk("post_rst_key_alful", {31'd0, kif.key_alful}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", {31'd0, kif.id_wr}, 32'd0);
    end
    send(K1, 1'b1, 1'b1, MISS);
    drain("drain_post_rst_miss");
    chk("post_rst_miss_1", miss_cnt, 32'd1);
    cfg(4'd3, 1'b1, K1, 16'h0042);
    send(K1, 1'b1, 1'b1, 16'h0042);
    drain("drain_reconfig");
    chk("reconfig_hit_1", hit_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
